pic_bus_interface: RTL
======================

Name: pic_bus_interface

Overview:
Synchronous read/write front end of the PIC, directly upstream of the control logic. Samples the CPU bus pins (CS_n, WR_n, RD_n, A0, D), runs the ICW1→ICW4 initialization sequence, and issues one-cycle ICW/OCW received strobes with the latched write byte. It also drives the data bus for IRR/ISR/IMR status reads. Its outputs connect straight to the control logic's ICWs_Flags, OCWs_Flags and DATA_IN inputs.

Parameters:
SYNC_STAGES, 2, flop stages on every bus pin (CS_n, WR_n, RD_n, A0, D), all delayed together; minimum 2.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
CS_n  in  1  chip select, active low
WR_n  in  1  write strobe, active low
RD_n  in  1  read strobe, active low
A0  in  1  register address bit
D_IN  in  8  CPU write data
IMR_IN  in  8  current mask register, from control logic
IRR_IN  in  8  interrupt request register
ISR_IN  in  8  in-service register
Read_command  in  2  OCW3[1:0], from control logic
ICWs_Flags  out  4  one-cycle strobes; bit0..3 = ICW1..ICW4
OCWs_Flags  out  3  one-cycle strobes; bit0..2 = OCW1..OCW3
DATA_OUT  out  8  last committed write byte
init_done  out  1  high when the init FSM is in READY
DB_OUT  out  8  read data to the CPU bus
DB_OE  out  1  bus output enable

Behaviour:
- Reset (async, RST=1): all outputs 0; FSM goes to IDLE; sync pipeline, captured SNGL/IC4 and DB_OUT cleared. Any write in flight is lost.
- Sampling: CS_n, WR_n, RD_n, A0 and D_IN pass through the same SYNC_STAGES pipeline, so they stay aligned. The bus must hold A0/D/CS_n stable while WR_n is low, and WR_n must stay low for at least 2 clocks.
- Write commit: on a 0→1 transition of synced WR_n where synced CS_n was 0 in the previous sample. The byte and A0 used are those sampled in the last low-WR_n cycle.
- Commit timing: the flag pulse and the DATA_OUT update occur in the same cycle, SYNC_STAGES+1 clocks after WR_n rises at the pin. A flag pulse lasts exactly 1 cycle, and at most one flag bit is high in any cycle. DATA_OUT holds its value until the next committed write.
- Init FSM states: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
  - A0=0 with D[4]=1 is ICW1 in any state: pulse ICWs_Flags[0], capture SNGL=D[1] and IC4=D[0], go to WAIT_ICW2.
  - WAIT_ICW2, A0=1: pulse ICWs_Flags[1]. Next state is WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW3, A0=1: pulse ICWs_Flags[2]. Next state is WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW4, A0=1: pulse ICWs_Flags[3], go to READY.
  - READY: A0=1 gives OCW1. A0=0 with D[4:3]=00 gives OCW2. A0=0 with D[4:3]=01 gives OCW3.
  - Ignored (no flag, DATA_OUT unchanged): writes in IDLE other than ICW1, and A0=0 non-ICW1 writes during WAIT_*.
- Read path: active when synced RD_n=0, CS_n=0, WR_n=1 and state is READY.
  - DB_OE is registered and asserts the cycle after the condition becomes true; it deasserts the cycle after the condition drops.
  - DB_OUT selection: A0=1 gives IMR_IN. A0=0 gives ISR_IN if Read_command=2'b11, otherwise IRR_IN.
  - DB_OUT is re-registered every cycle while the read is active.
- Simultaneous RD_n and WR_n low: the write proceeds and DB_OE is forced to 0.
- Reads outside READY: DB_OE stays 0 and DB_OUT holds.

Decomposition:
- Package pic_pkg holds:
  - FSM state encoding;
  - ICW/OCW flag bit indices;
  - Read_command codes (RD_IRR=2'b10, RD_ISR=2'b11);
  - D-bit positions for the ICW1 flag, SNGL and IC4.
- Sub-module pic_sync: parameterized width × SYNC_STAGES flop pipeline with async reset, instantiated once for the 12-bit bus bundle.

Test Plan:
1. Single-mode init: ICW1=0x13 (A0=0), ICW2=0x40 (A0=1), ICW4=0x03 (A0=1) → ICWs_Flags pulses 0001, 0010, 1000 in order with no 0100; init_done=1 after ICW4; DATA_OUT=0x03; each pulse lands SYNC_STAGES+1 clocks after WR_n rises.
2. Cascade init: ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x01 → ICWs_Flags bits 0, 1, 2, 3 in sequence; DATA_OUT tracks 0x11, 0x08, 0x04, 0x01.
3. OCW decode in READY: A0=1 0xFB → OCW1 strobe (001) with DATA_OUT=0xFB; A0=0 0x20 → 010; A0=0 0x0B → 100; ICWs_Flags stay 0.
4. Status read with IRR_IN=0x81, ISR_IN=0x04, IMR_IN=0xFB: Read_command=11, A0=0 → DB_OUT=0x04, DB_OE=1; Read_command=10 → 0x81; A0=1 → 0xFB; CS_n=1 → DB_OE=0.
5. Sequence corner cases: ICW1 0x10, ICW2, then ICW1 0x13 again → FSM back to WAIT_ICW2, init_done=0. From reset, A0=1 write 0x55 → no flags, DATA_OUT stays 0x00. RD_n and WR_n both low → DB_OE=0.
6. Reset mid-write: assert RST while WR_n is low, release it, then raise WR_n → no flag pulse; all outputs 0; FSM in IDLE.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared encodings for the PIC bus front end: init FSM states, strobe bit
// positions, read-back selectors and control-bit positions in the write byte.
package pic_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitIcw2,
        StWaitIcw3,
        StWaitIcw4,
        StReady
    } pic_state_e;

    localparam int unsigned ICW1_IDX = 0;
    localparam int unsigned ICW2_IDX = 1;
    localparam int unsigned ICW3_IDX = 2;
    localparam int unsigned ICW4_IDX = 3;

    localparam int unsigned OCW1_IDX = 0;
    localparam int unsigned OCW2_IDX = 1;
    localparam int unsigned OCW3_IDX = 2;

    localparam logic [1:0] RD_IRR = 2'b10;
    localparam logic [1:0] RD_ISR = 2'b11;

    localparam int unsigned D_ICW1_FLAG = 4;
    localparam int unsigned D_OCW3_SEL  = 3;
    localparam int unsigned D_SNGL      = 1;
    localparam int unsigned D_IC4       = 0;

    // {CS_n, WR_n, RD_n, A0, D[7:0]}
    localparam int unsigned BUS_W = 12;

endpackage

// File: rtl/pic_sync.sv
// Multi-stage flop pipeline with async reset; all bits are delayed together so a
// bus bundle stays aligned.
module pic_sync #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [STAGES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/pic_bus_interface.sv
// PIC CPU-bus front end: synchronises the bus, runs the ICW1..ICW4 init sequence,
// emits one-cycle ICW/OCW strobes with the written byte, and serves status reads.
module pic_bus_interface
    import pic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CS_n,
    input  logic       WR_n,
    input  logic       RD_n,
    input  logic       A0,
    input  logic [7:0] D_IN,
    input  logic [7:0] IMR_IN,
    input  logic [7:0] IRR_IN,
    input  logic [7:0] ISR_IN,
    input  logic [1:0] Read_command,
    output logic [3:0] ICWs_Flags,
    output logic [2:0] OCWs_Flags,
    output logic [7:0] DATA_OUT,
    output logic       init_done,
    output logic [7:0] DB_OUT,
    output logic       DB_OE
);

    logic [BUS_W-1:0] w_sync;
    logic             w_cs_n, w_wr_n, w_rd_n, w_a0;
    logic [7:0]       w_d;

    pic_sync #(
        .WIDTH  (BUS_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   ({CS_n, WR_n, RD_n, A0, D_IN}),
        .o_q   (w_sync)
    );

    assign {w_cs_n, w_wr_n, w_rd_n, w_a0, w_d} = w_sync;

    logic       r_prev_cs_n, r_prev_wr_n, r_prev_a0, r_armed;
    logic [7:0] r_prev_d;
    logic       w_commit;

    // r_armed requires one high WR_n sample after reset, so a write whose low
    // phase straddled reset never commits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_prev_cs_n <= 1'b0;
            r_prev_wr_n <= 1'b0;
            r_prev_a0   <= 1'b0;
            r_prev_d    <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_prev_cs_n <= w_cs_n;
            r_prev_wr_n <= w_wr_n;
            r_prev_a0   <= w_a0;
            r_prev_d    <= w_d;
            r_armed     <= r_armed | r_prev_wr_n;
        end
    end

    assign w_commit = r_armed & ~r_prev_wr_n & w_wr_n & ~r_prev_cs_n;

    pic_state_e r_state;
    logic       r_sngl, r_ic4;
    logic [3:0] r_icw;
    logic [2:0] r_ocw;
    logic [7:0] r_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
            r_sngl  <= 1'b0;
            r_ic4   <= 1'b0;
            r_icw   <= '0;
            r_ocw   <= '0;
            r_data  <= '0;
        end else begin
            r_icw <= '0;
            r_ocw <= '0;
            if (w_commit) begin
                if (!r_prev_a0 && r_prev_d[D_ICW1_FLAG]) begin
                    r_icw[ICW1_IDX] <= 1'b1;
                    r_sngl          <= r_prev_d[D_SNGL];
                    r_ic4           <= r_prev_d[D_IC4];
                    r_data          <= r_prev_d;
                    r_state         <= StWaitIcw2;
                end else if (r_prev_a0) begin
                    case (r_state)
                        StWaitIcw2: begin
                            r_icw[ICW2_IDX] <= 1'b1;
                            r_data          <= r_prev_d;
                            r_state         <= !r_sngl ? StWaitIcw3 :
                                               r_ic4   ? StWaitIcw4 : StReady;
                        end
                        StWaitIcw3: begin
                            r_icw[ICW3_IDX] <= 1'b1;
                            r_data          <= r_prev_d;
                            r_state         <= r_ic4 ? StWaitIcw4 : StReady;
                        end
                        StWaitIcw4: begin
                            r_icw[ICW4_IDX] <= 1'b1;
                            r_data          <= r_prev_d;
                            r_state         <= StReady;
                        end
                        StReady: begin
                            r_ocw[OCW1_IDX] <= 1'b1;
                            r_data          <= r_prev_d;
                        end
                        default: ;
                    endcase
                end else if (r_state == StReady) begin
                    // D[4] is known 0 here, so D[3] alone picks OCW2 vs OCW3
                    if (r_prev_d[D_OCW3_SEL]) r_ocw[OCW3_IDX] <= 1'b1;
                    else                      r_ocw[OCW2_IDX] <= 1'b1;
                    r_data <= r_prev_d;
                end
            end
        end
    end

    logic       w_rd_active;
    logic [7:0] w_rd_data;
    logic       r_db_oe;
    logic [7:0] r_db_out;

    assign w_rd_active = ~w_rd_n & ~w_cs_n & w_wr_n & (r_state == StReady);

    always_comb begin
        w_rd_data = IRR_IN;
        if (w_a0) begin
            w_rd_data = IMR_IN;
        end else begin
            case (Read_command)
                RD_ISR:  w_rd_data = ISR_IN;
                RD_IRR:  w_rd_data = IRR_IN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_db_oe  <= 1'b0;
            r_db_out <= '0;
        end else begin
            r_db_oe <= w_rd_active;
            if (w_rd_active) r_db_out <= w_rd_data;
        end
    end

    assign ICWs_Flags = r_icw;
    assign OCWs_Flags = r_ocw;
    assign DATA_OUT   = r_data;
    assign init_done  = (r_state == StReady);
    assign DB_OUT     = r_db_out;
    assign DB_OE      = r_db_oe;

endmodule
